// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and default sizing for the FIFO write arbiter
package fifo_arb_pkg;
  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int ID_W          = $clog2(NUM_REQ_DEF);
  localparam int CNT_W         = $clog2(MAX_BURST_DEF + 1);

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first requester after last_id wins
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_id,
  output logic          any,
  output logic [IW-1:0] pick_id
);
  assign any = |req;

  // Lowest requester overall is the wrap-around fallback; lowest one above last_id overrides it.
  always_comb begin
    pick_id = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) pick_id = IW'(j);
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(last_id))) pick_id = IW'(j);
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among producers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_din,
  output logic                        gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e        state, state_n;
  logic [IW-1:0]     last_id, gnt_n, last_n, pick_id;
  logic [CW-1:0]     beat_cnt, cnt_n;
  logic              any_req, cur_valid, beat;
  logic [DATA_W-1:0] slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .last_id (last_id),
    .any     (any_req),
    .pick_id (pick_id)
  );

  assign gnt_valid = (state == ARB_GRANT);
  assign cur_valid = req_valid[gnt_id];
  assign beat      = gnt_valid & cur_valid & ~fifo_full & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt_id   <= '0;
      last_id  <= LAST_RST;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt_id   <= gnt_n;
      last_id  <= last_n;
      beat_cnt <= cnt_n;
    end
  end

  // A full FIFO freezes the burst; only a withdrawn valid or the final beat ends it.
  always_comb begin
    state_n = state;
    gnt_n   = gnt_id;
    last_n  = last_id;
    cnt_n   = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_n = ARB_GRANT;
          gnt_n   = pick_id;
          cnt_n   = '0;
        end
      end
      ARB_GRANT: begin
        if (!cur_valid || (beat && (beat_cnt == CNT_LAST))) begin
          state_n = ARB_IDLE;
          last_n  = gnt_id;
          cnt_n   = '0;
        end else if (beat) begin
          cnt_n = beat_cnt + CW'(1);
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_din  = '0;
    if (gnt_valid && !rst) begin
      req_ready[gnt_id] = ~fifo_full;
      fifo_wr           = beat;
      fifo_din          = slice[gnt_id];
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - vector table plus scoreboarded producer sequences for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        gnt_valid;
  logic [1:0]  gnt_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic [3:0]  rdy;
    logic        wr;
    logic [7:0]  din;
    logic        gv;
    logic [1:0]  gid;
  } vec_t;

  vec_t       vecs [16];
  logic [7:0] src_q [4][$];
  logic [7:0] exp_q [4][$];
  logic [9:0] fifo_log [$];
  logic [3:0] en;
  logic       force_full, model_on;
  logic       s_wr, s_gv;
  logic [3:0] s_rdy;
  logic [7:0] s_din;
  logic [1:0] s_gid;
  int         n_checks, n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_beat(input int id, input logic [7:0] d);
    src_q[id].push_back(d);
    exp_q[id].push_back(d);
  endtask

  // One clock: drive inputs, sample mid-cycle, take the edge, retire accepted producer beats.
  task automatic cycle();
    logic [3:0] hs;
    logic [7:0] want;
    if (model_on) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i]        = en[i] && (src_q[i].size() > 0);
        req_data[i*8 +: 8]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
      fifo_full = force_full;
    end
    #4;
    s_wr = fifo_wr; s_rdy = req_ready; s_din = fifo_din; s_gv = gnt_valid; s_gid = gnt_id;
    hs = req_valid & req_ready;
    check("inv_wr_needs_grant", 32'(fifo_wr && !(gnt_valid && !fifo_full)), 32'(0));
    check("inv_ready_onehot", 32'($countones(req_ready) > 1), 32'(0));
    if (model_on && fifo_wr) begin
      fifo_log.push_back({gnt_id, fifo_din});
      if (exp_q[gnt_id].size() == 0) begin
        n_checks++;
        $display("FAIL sb_extra_beat: got %0h from producer %0d expected no beat", fifo_din, gnt_id);
      end else begin
        want = exp_q[gnt_id].pop_front();
        check($sformatf("sb_order_p%0d", gnt_id), 32'(fifo_din), 32'(want));
      end
    end
    @(posedge clk); #1;
    if (model_on)
      for (int i = 0; i < 4; i++) if (hs[i]) void'(src_q[i].pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    en = 4'hF;
    force_full = 1'b0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) != 0 && guard < 200) begin
      cycle();
      guard++;
    end
    check({tag, "_drain_bound"}, 32'(guard < 200), 32'(1));
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) check($sformatf("%s_left_p%0d", tag, i), 32'(exp_q[i].size()), 32'(0));
    fifo_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    model_on = 1'b0; en = 4'hF; force_full = 1'b0;

    // rst, valid, data, full | ready, wr, din, gnt_valid, gnt_id
    vecs[0]  = '{1'b1, 4'hF, 32'hD3C2B1A0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 4'hF, 32'hD3C2B1A0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 1'b0, 4'h1, 1'b1, 8'hA0, 1'b1, 2'd0};
    vecs[4]  = '{1'b0, 4'h0, 32'hD3C2B1A0, 1'b0, 4'h1, 1'b0, 8'hA0, 1'b1, 2'd0};
    vecs[5]  = '{1'b0, 4'h0, 32'hD3C2B1A0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 4'h2, 32'hD3C2A1A0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 4'h2, 32'hD3C2A1A0, 1'b0, 4'h2, 1'b1, 8'hA1, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 4'h2, 32'hD3C2A2A0, 1'b0, 4'h2, 1'b1, 8'hA2, 1'b1, 2'd1};
    vecs[9]  = '{1'b0, 4'h2, 32'hD3C2A3A0, 1'b0, 4'h2, 1'b1, 8'hA3, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 4'h0, 32'hD3C2A3A0, 1'b0, 4'h2, 1'b0, 8'hA3, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 4'h0, 32'hD3C2A3A0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1};
    vecs[12] = '{1'b0, 4'h5, 32'hD3C2A3A0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1};
    vecs[13] = '{1'b0, 4'h5, 32'hD3C2A3A0, 1'b0, 4'h4, 1'b1, 8'hC2, 1'b1, 2'd2};
    vecs[14] = '{1'b0, 4'h0, 32'hD3C2A3A0, 1'b1, 4'h0, 1'b0, 8'hC2, 1'b1, 2'd2};
    vecs[15] = '{1'b0, 4'h0, 32'hD3C2A3A0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2};

    @(posedge clk); #1;
    for (int r = 0; r < 16; r++) begin
      rst = vecs[r].rst; req_valid = vecs[r].valid; req_data = vecs[r].data; fifo_full = vecs[r].full;
      cycle();
      check($sformatf("v%0d_ready", r), 32'(s_rdy), 32'(vecs[r].rdy));
      check($sformatf("v%0d_wr", r), 32'(s_wr), 32'(vecs[r].wr));
      check($sformatf("v%0d_din", r), 32'(s_din), 32'(vecs[r].din));
      check($sformatf("v%0d_gnt_valid", r), 32'(s_gv), 32'(vecs[r].gv));
      check($sformatf("v%0d_gnt_id", r), 32'(s_gid), 32'(vecs[r].gid));
    end

    model_on = 1'b1;

    // Rotation: grants 0,1,2,3,0 of four beats each, one idle cycle before each grant.
    do_reset();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 8; k++) push_beat(i, 8'(i * 16 + k));
    for (int k = 0; k < 25; k++) begin
      cycle();
      check($sformatf("rot%0d_gnt_valid", k), 32'(s_gv), 32'((k % 5) != 0));
      check($sformatf("rot%0d_wr", k), 32'(s_wr), 32'((k % 5) != 0));
      if ((k % 5) != 0) check($sformatf("rot%0d_gnt_id", k), 32'(s_gid), 32'((k / 5) % 4));
    end
    drain("rot");

    // Backpressure during producer 2's burst.
    do_reset();
    for (int k = 0; k < 5; k++) push_beat(2, 8'(8'h20 + k));
    cycle(); check("bp_idle", 32'(s_gv), 32'(0));
    cycle(); check("bp_b1_id", 32'(s_gid), 32'(2)); check("bp_b1_wr", 32'(s_wr), 32'(1));
    cycle(); check("bp_b2_wr", 32'(s_wr), 32'(1));
    force_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cycle();
      check($sformatf("bp_stall%0d_wr", s), 32'(s_wr), 32'(0));
      check($sformatf("bp_stall%0d_ready", s), 32'(s_rdy), 32'(0));
      check($sformatf("bp_stall%0d_gnt", s), 32'({s_gv, s_gid}), 32'({1'b1, 2'd2}));
      check($sformatf("bp_stall%0d_cnt", s), 32'(dut.beat_cnt), 32'(2));
    end
    force_full = 1'b0;
    cycle(); check("bp_b3_wr", 32'(s_wr), 32'(1));
    cycle(); check("bp_b4_wr", 32'(s_wr), 32'(1));
    cycle(); check("bp_release", 32'(s_gv), 32'(0));
    cycle(); check("bp_regrant", 32'({s_gv, s_gid, s_wr}), 32'({1'b1, 2'd2, 1'b1}));
    drain("bp");

    // Reset in the middle of producer 3's burst.
    do_reset();
    for (int k = 0; k < 4; k++) push_beat(3, 8'(8'h30 + k));
    for (int k = 0; k < 2; k++) push_beat(0, 8'(8'h0A + k));
    en = 4'b1000;
    cycle(); check("mr_idle", 32'(s_gv), 32'(0));
    cycle(); check("mr_b1", 32'({s_gv, s_gid, s_wr}), 32'({1'b1, 2'd3, 1'b1}));
    en = 4'hF;
    rst = 1'b1;
    cycle(); check("mr_rst_wr", 32'(s_wr), 32'(0)); check("mr_rst_ready", 32'(s_rdy), 32'(0));
    rst = 1'b0;
    cycle(); check("mr_after_gv", 32'(s_gv), 32'(0));
    check("mr_fifo_count", 32'(fifo_log.size()), 32'(1));
    if (fifo_log.size() > 0) check("mr_fifo_entry", 32'(fifo_log[0]), 32'({2'd3, 8'h30}));
    cycle(); check("mr_first_grant", 32'({s_gv, s_gid}), 32'({1'b1, 2'd0}));
    drain("mr");

    // Producer 0 drops valid after one beat; next grant must be 1.
    do_reset();
    push_beat(0, 8'h5A);
    for (int k = 0; k < 2; k++) begin push_beat(1, 8'(8'h60 + k)); push_beat(2, 8'(8'h70 + k)); end
    cycle(); check("ed_idle", 32'(s_gv), 32'(0));
    cycle(); check("ed_b1", 32'({s_gv, s_gid, s_wr}), 32'({1'b1, 2'd0, 1'b1}));
    cycle(); check("ed_drop", 32'({s_gv, s_gid, s_wr}), 32'({1'b1, 2'd0, 1'b0}));
    cycle(); check("ed_bubble", 32'(s_gv), 32'(0));
    cycle(); check("ed_next", 32'({s_gv, s_gid, s_wr}), 32'({1'b1, 2'd1, 1'b1}));
    drain("ed");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
